// File: rtl/mem_pkg.sv
// Shared defaults and FSM state encoding for the block-memory responder.
package mem_pkg;

    localparam int DEF_DATA_WIDTH   = 16;
    localparam int DEF_TAG_WIDTH    = 16;
    localparam int DEF_BLOCK_SIZE   = 4;
    localparam int DEF_OFFSET_WIDTH = 2;
    localparam int DEF_READ_LATENCY = 3;
    localparam int LAT_WIDTH        = 4;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RBURST,
        WBURST
    } state_e;

endpackage

// File: rtl/mem_responder_if.sv
// Request / write-beat / read-beat bundle between a block requester and the responder.
interface mem_responder_if
    import mem_pkg::*;
#(
    parameter int DATA_WIDTH   = DEF_DATA_WIDTH,
    parameter int TAG_WIDTH    = DEF_TAG_WIDTH,
    parameter int OFFSET_WIDTH = DEF_OFFSET_WIDTH
);

    logic                    req_valid;
    logic                    req_ready;
    logic                    req_write;
    logic [TAG_WIDTH-1:0]    req_tag;
    logic                    wr_valid;
    logic                    wr_ready;
    logic [DATA_WIDTH-1:0]   wr_data;
    logic                    resp_valid;
    logic                    resp_ready;
    logic [DATA_WIDTH-1:0]   resp_data;
    logic [OFFSET_WIDTH-1:0] resp_offset;
    logic                    resp_last;

    modport master (
        output req_valid, req_write, req_tag, wr_valid, wr_data, resp_ready,
        input  req_ready, wr_ready, resp_valid, resp_data, resp_offset, resp_last
    );

    modport slave (
        input  req_valid, req_write, req_tag, wr_valid, wr_data, resp_ready,
        output req_ready, wr_ready, resp_valid, resp_data, resp_offset, resp_last
    );

endinterface

// File: rtl/mem_block_store.sv
// Word storage addressed by {tag, offset}: synchronous write, combinational read.
module mem_block_store #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 18
) (
    input  logic                  clk,
    input  logic                  we_i,
    input  logic [ADDR_WIDTH-1:0] addr_i,
    input  logic [DATA_WIDTH-1:0] wdata_i,
    output logic [DATA_WIDTH-1:0] rdata_o
);

    logic [DATA_WIDTH-1:0] mem_q [2**ADDR_WIDTH];

    // Contents deliberately survive reset; there is no reset branch.
    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[addr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[addr_i];

endmodule

// File: rtl/mem_responder.sv
// Block memory responder: accepts block fill reads (with fixed latency) and block write-backs.
module mem_responder
    import mem_pkg::*;
#(
    parameter int DATA_WIDTH   = DEF_DATA_WIDTH,
    parameter int TAG_WIDTH    = DEF_TAG_WIDTH,
    parameter int BLOCK_SIZE   = DEF_BLOCK_SIZE,
    parameter int OFFSET_WIDTH = DEF_OFFSET_WIDTH,
    parameter int READ_LATENCY = DEF_READ_LATENCY
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic                    req_write,
    input  logic [TAG_WIDTH-1:0]    req_tag,
    input  logic                    wr_valid,
    output logic                    wr_ready,
    input  logic [DATA_WIDTH-1:0]   wr_data,
    output logic                    resp_valid,
    input  logic                    resp_ready,
    output logic [DATA_WIDTH-1:0]   resp_data,
    output logic [OFFSET_WIDTH-1:0] resp_offset,
    output logic                    resp_last,
    output logic [31:0]             read_count,
    output logic [31:0]             write_count
);

    localparam logic [OFFSET_WIDTH-1:0] LAST_BEAT = OFFSET_WIDTH'(BLOCK_SIZE - 1);

    state_e                  state_q, state_d;
    logic [OFFSET_WIDTH-1:0] beat_q, beat_d;
    logic [LAT_WIDTH-1:0]    lat_q, lat_d;
    logic [TAG_WIDTH-1:0]    tag_q, tag_d;
    logic [31:0]             rd_cnt_q, rd_cnt_d;
    logic [31:0]             wr_cnt_q, wr_cnt_d;
    logic [DATA_WIDTH-1:0]   rdata;
    logic                    we;

    mem_block_store #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (TAG_WIDTH + OFFSET_WIDTH)
    ) u_store (
        .clk     (clk),
        .we_i    (we),
        .addr_i  ({tag_q, beat_q}),
        .wdata_i (wr_data),
        .rdata_o (rdata)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            beat_q   <= '0;
            lat_q    <= '0;
            tag_q    <= '0;
            rd_cnt_q <= '0;
            wr_cnt_q <= '0;
        end else begin
            state_q  <= state_d;
            beat_q   <= beat_d;
            lat_q    <= lat_d;
            tag_q    <= tag_d;
            rd_cnt_q <= rd_cnt_d;
            wr_cnt_q <= wr_cnt_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        beat_d   = beat_q;
        lat_d    = lat_q;
        tag_d    = tag_q;
        rd_cnt_d = rd_cnt_q;
        wr_cnt_d = wr_cnt_q;
        we       = 1'b0;
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    tag_d  = req_tag;
                    beat_d = '0;
                    if (req_write) begin
                        state_d = WBURST;
                    end else begin
                        state_d = WAIT;
                        lat_d   = LAT_WIDTH'(READ_LATENCY - 1);
                    end
                end
            end
            WAIT: begin
                if (lat_q == '0) begin
                    state_d = RBURST;
                end else begin
                    lat_d = lat_q - 1'b1;
                end
            end
            RBURST: begin
                if (resp_ready) begin
                    beat_d = beat_q + 1'b1;
                    if (beat_q == LAST_BEAT) begin
                        state_d  = IDLE;
                        rd_cnt_d = rd_cnt_q + 32'd1;
                    end
                end
            end
            WBURST: begin
                if (wr_valid) begin
                    we     = 1'b1;
                    beat_d = beat_q + 1'b1;
                    if (beat_q == LAST_BEAT) begin
                        state_d  = IDLE;
                        wr_cnt_d = wr_cnt_q + 32'd1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign req_ready   = (state_q == IDLE);
    assign wr_ready    = (state_q == WBURST);
    assign resp_valid  = (state_q == RBURST);
    assign resp_data   = resp_valid ? rdata : '0;
    assign resp_offset = resp_valid ? beat_q : '0;
    assign resp_last   = resp_valid && (beat_q == LAST_BEAT);
    assign read_count  = rd_cnt_q;
    assign write_count = wr_cnt_q;

endmodule

// File: tb/tb_mem_responder.sv
// Directed self-checking bench for mem_responder.
module tb_mem_responder;

    logic        clk;
    logic        reset;
    logic [31:0] read_count;
    logic [31:0] write_count;
    int          n_checks;
    int          n_errors;

    mem_responder_if #(
        .DATA_WIDTH   (16),
        .TAG_WIDTH    (16),
        .OFFSET_WIDTH (2)
    ) bus ();

    mem_responder #(
        .DATA_WIDTH   (16),
        .TAG_WIDTH    (16),
        .BLOCK_SIZE   (4),
        .OFFSET_WIDTH (2),
        .READ_LATENCY (3)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .req_valid   (bus.req_valid),
        .req_ready   (bus.req_ready),
        .req_write   (bus.req_write),
        .req_tag     (bus.req_tag),
        .wr_valid    (bus.wr_valid),
        .wr_ready    (bus.wr_ready),
        .wr_data     (bus.wr_data),
        .resp_valid  (bus.resp_valid),
        .resp_ready  (bus.resp_ready),
        .resp_data   (bus.resp_data),
        .resp_offset (bus.resp_offset),
        .resp_last   (bus.resp_last),
        .read_count  (read_count),
        .write_count (write_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        #1;
        check("rst_resp_valid", 32'(bus.resp_valid), 32'd0);
        check("rst_resp_data", 32'(bus.resp_data), 32'd0);
        check("rst_resp_offset", 32'(bus.resp_offset), 32'd0);
        check("rst_resp_last", 32'(bus.resp_last), 32'd0);
        check("rst_wr_ready", 32'(bus.wr_ready), 32'd0);
        check("rst_read_count", read_count, 32'd0);
        check("rst_write_count", write_count, 32'd0);
        tick();
        tick();
        reset = 1'b0;
        #1;
        check("rst_req_ready", 32'(bus.req_ready), 32'd1);
    endtask

    task automatic write_block(input logic [15:0] tag, input logic [15:0] base);
        check("wr_req_ready", 32'(bus.req_ready), 32'd1);
        bus.req_valid = 1'b1;
        bus.req_write = 1'b1;
        bus.req_tag   = tag;
        tick();
        bus.req_valid = 1'b0;
        check("wr_ready_burst", 32'(bus.wr_ready), 32'd1);
        for (int j = 0; j < 4; j++) begin
            bus.wr_valid = 1'b1;
            bus.wr_data  = base + 16'(j);
            tick();
        end
        bus.wr_valid = 1'b0;
        check("wr_ready_done", 32'(bus.wr_ready), 32'd0);
        check("wr_idle", 32'(bus.req_ready), 32'd1);
    endtask

    // stall_beat < 0 disables the stall; pulse injects a second request while busy.
    task automatic read_block(input logic [15:0] tag, input logic [15:0] base,
                              input int stall_beat, input bit pulse);
        int cyc;
        bus.resp_ready = 1'b1;
        check("rd_req_ready", 32'(bus.req_ready), 32'd1);
        bus.req_valid = 1'b1;
        bus.req_write = 1'b0;
        bus.req_tag   = tag;
        tick();
        bus.req_valid = 1'b0;
        check("rd_wait_valid", 32'(bus.resp_valid), 32'd0);
        cyc = 0;
        if (pulse) begin
            bus.req_valid = 1'b1;
            bus.req_tag   = 16'h0002;
            check("busy_req_ready", 32'(bus.req_ready), 32'd0);
            tick();
            bus.req_valid = 1'b0;
            cyc = 1;
        end
        while (!bus.resp_valid && cyc < 20) begin
            tick();
            cyc++;
        end
        check("rd_latency", 32'(cyc), 32'd3);
        check("rd_valid", 32'(bus.resp_valid), 32'd1);
        for (int j = 0; j < 4; j++) begin
            if (j == stall_beat) begin
                bus.resp_ready = 1'b0;
                for (int k = 0; k < 2; k++) begin
                    tick();
                    check("stall_data", 32'(bus.resp_data), 32'(base + 16'(j)));
                    check("stall_offset", 32'(bus.resp_offset), 32'(j));
                end
                bus.resp_ready = 1'b1;
            end
            check("beat_data", 32'(bus.resp_data), 32'(base + 16'(j)));
            check("beat_offset", 32'(bus.resp_offset), 32'(j));
            check("beat_last", 32'(bus.resp_last), (j == 3) ? 32'd1 : 32'd0);
            tick();
        end
        check("rd_done_valid", 32'(bus.resp_valid), 32'd0);
        check("rd_done_data", 32'(bus.resp_data), 32'd0);
        check("rd_done_ready", 32'(bus.req_ready), 32'd1);
    endtask

    initial begin
        n_checks       = 0;
        n_errors       = 0;
        reset          = 1'b1;
        bus.req_valid  = 1'b0;
        bus.req_write  = 1'b0;
        bus.req_tag    = '0;
        bus.wr_valid   = 1'b0;
        bus.wr_data    = '0;
        bus.resp_ready = 1'b1;
        tick();
        do_reset();

        // Preload through the bus with mem[i][j] = i*4+j, then reset to clear counters only.
        write_block(16'h42bb, 16'h0AEC);
        write_block(16'h0001, 16'h0004);
        write_block(16'h0002, 16'h0008);
        check("preload_wcount", write_count, 32'd3);
        do_reset();

        read_block(16'h42bb, 16'h0AEC, -1, 1'b0);
        check("r1_read_count", read_count, 32'd1);
        check("r1_write_count", write_count, 32'd0);

        do_reset();
        write_block(16'h0005, 16'h00A0);
        check("w_write_count", write_count, 32'd1);
        bus.wr_valid = 1'b1;
        bus.wr_data  = 16'hDEAD;
        check("idle_wr_ready", 32'(bus.wr_ready), 32'd0);
        tick();
        bus.wr_valid = 1'b0;
        read_block(16'h0005, 16'h00A0, -1, 1'b0);
        check("w_write_count2", write_count, 32'd1);
        check("w_read_count", read_count, 32'd1);

        do_reset();
        read_block(16'h0001, 16'h0004, 1, 1'b0);
        check("stall_read_count", read_count, 32'd1);

        do_reset();
        read_block(16'h0001, 16'h0004, -1, 1'b1);
        repeat (8) tick();
        check("pulse_no_resp", 32'(bus.resp_valid), 32'd0);
        check("pulse_read_count", read_count, 32'd1);

        do_reset();
        bus.resp_ready = 1'b1;
        bus.req_valid  = 1'b1;
        bus.req_write  = 1'b0;
        bus.req_tag    = 16'h42bb;
        tick();
        bus.req_valid = 1'b0;
        begin
            int cyc;
            cyc = 0;
            while (!bus.resp_valid && cyc < 20) begin
                tick();
                cyc++;
            end
            check("abort_latency", 32'(cyc), 32'd3);
        end
        tick();
        tick();
        check("abort_offset", 32'(bus.resp_offset), 32'd2);
        check("abort_data", 32'(bus.resp_data), 32'h0AEE);
        reset = 1'b1;
        #1;
        check("abort_valid", 32'(bus.resp_valid), 32'd0);
        check("abort_zero_data", 32'(bus.resp_data), 32'd0);
        check("abort_read_count", read_count, 32'd0);
        tick();
        reset = 1'b0;
        #1;
        read_block(16'h42bb, 16'h0AEC, -1, 1'b0);
        check("after_abort_count", read_count, 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
